feature_row_mac: RTL

Feature-transform stage fed by the feature row counter. For each feature row it streams FEATURE_COLS feature elements and the matching weight elements from on-chip memories and accumulates their dot product. It presents one result per row on a valid/ready output and pulses the counter's enable to advance to the next row. Sits between the feature/weight memories plus the feature counter (upstream) and the aggregation/output buffer (downstream).

---
 rtl/feature_row_mac.sv | 115 +++++++++++
 1 files changed

// File: rtl/feature_row_mac.sv
// Feature-row dot-product stage: streams one feature row and the weight vector
// from memory, accumulates their products and hands one result per row downstream.
module feature_row_mac #(
  parameter int FEATURE_ROWS          = 6,
  parameter int FEATURE_COLS          = 96,
  parameter int DATA_WIDTH            = 5,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_COL_WIDTH     = $clog2(FEATURE_COLS),
  parameter int ACC_WIDTH             = 2*DATA_WIDTH + $clog2(FEATURE_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [COUNTER_FEATURE_WIDTH-1:0] counter_feature,
  output logic                             enable_feature,
  output logic                             read_en,
  output logic [COUNTER_FEATURE_WIDTH-1:0] read_row,
  output logic [COUNTER_COL_WIDTH-1:0]     read_col,
  input  logic [DATA_WIDTH-1:0]            feature_data,
  input  logic [DATA_WIDTH-1:0]            weight_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             out_data,
  output logic [COUNTER_FEATURE_WIDTH-1:0] out_row,
  output logic                             busy,
  output logic                             done
);

  // Output handshake: a result transfers on any cycle where out_valid and
  // out_ready are both high; out_valid, out_data and out_row hold until then.
  typedef enum logic [2:0] {IDLE, READ, DRAIN, OUTPUT, DONE} state_t;

  state_t                           state;
  state_t                           state_next;
  logic                             rd_valid;
  logic [ACC_WIDTH-1:0]             acc;
  logic [ACC_WIDTH-1:0]             acc_next;
  logic [ACC_WIDTH-1:0]             product;
  logic [2*DATA_WIDTH-1:0]          mult;
  logic [COUNTER_FEATURE_WIDTH-1:0] row_cnt;
  logic                             last_col;
  logic                             last_row;
  logic                             handshake;

  assign mult      = feature_data * weight_data;
  assign product   = {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, mult};
  assign acc_next  = rd_valid ? acc + product : acc;
  assign last_col  = (read_col == COUNTER_COL_WIDTH'(FEATURE_COLS-1));
  assign last_row  = (row_cnt == COUNTER_FEATURE_WIDTH'(FEATURE_ROWS-1));
  assign handshake = (state == OUTPUT) && out_ready;

  assign enable_feature = handshake;
  assign out_valid      = (state == OUTPUT);
  assign busy           = (state != IDLE);
  assign read_row       = counter_feature;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = READ;
      READ:    if (last_col) state_next = DRAIN;
      DRAIN:   state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = last_row ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      read_en  <= 1'b0;
      read_col <= '0;
      rd_valid <= 1'b0;
      acc      <= '0;
      row_cnt  <= '0;
      out_data <= '0;
      out_row  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= read_en;
      read_en  <= (state_next == READ);
      done     <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            read_col <= '0;
            row_cnt  <= '0;
          end
        end
        READ: begin
          acc <= acc_next;
          if (!last_col) read_col <= read_col + 1'b1;
        end
        // The final element arrives here, one cycle behind its read strobe.
        DRAIN: begin
          acc      <= acc_next;
          out_data <= acc_next;
          out_row  <= row_cnt;
        end
        OUTPUT: begin
          if (out_ready) begin
            acc      <= '0;
            read_col <= '0;
            if (!last_row) row_cnt <= row_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
